// File: rtl/sc_dpram_pkg.sv
// Shared types, constants and helpers for the sc_dual_port_ram_be RAM.
// The optional parity feature is enabled by defining SC_DPRAM_PARITY_EN.
package sc_dpram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  // Upper bounds for the width-generic parity helper.
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_BE_WIDTH   = 128;
  localparam int DATA_IDX_W     = $clog2(MAX_DATA_WIDTH);
  localparam int BE_IDX_W       = $clog2(MAX_BE_WIDTH);

  function automatic int calc_be_width(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // Even parity per lane: the stored bit makes each lane plus its parity bit even.
  function automatic logic [MAX_BE_WIDTH-1:0] calc_lane_parity(
    input logic [MAX_DATA_WIDTH-1:0] data,
    input int                        be_width,
    input int                        byte_width
  );
    logic [MAX_BE_WIDTH-1:0] par;
    par = '0;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (i < be_width * byte_width)
        par[BE_IDX_W'(i / byte_width)] = par[BE_IDX_W'(i / byte_width)] ^ data[DATA_IDX_W'(i)];
    end
    return par;
  endfunction

endpackage

// File: rtl/sc_dpram_clear_seq.sv
// Post-reset clear sequencer: sweeps zeros through the array, then raises ready
// and hands the write port to the user.
module sc_dpram_clear_seq
  import sc_dpram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [BE_WIDTH-1:0]   wr_be_i,
  input  logic                  rd_i,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  output logic                  rd_en_o,
  output logic                  ready_o
);

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  r_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == ST_RUN);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mem_wr_o    = wr_i & r_ready;
    mem_addr_o  = wr_addr_i;
    mem_data_o  = wr_data_i;
    mem_be_o    = wr_be_i;
    case (r_state)
      ST_CLEAR: begin
        mem_wr_o   = 1'b1;
        mem_addr_o = r_cnt;
        mem_data_o = '0;
        mem_be_o   = '1;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == '1) w_state_nxt = ST_RUN;
      end
      default: ;
    endcase
  end

  assign rd_en_o = rd_i & r_ready;
  assign ready_o = r_ready;

endmodule

// File: rtl/sc_dual_port_ram_be.sv
// Single-clock simple dual-port RAM with byte enables, 1/2-cycle read latency and
// defined read-during-write. Define SC_DPRAM_PARITY_EN for per-lane parity checking.
module sc_dual_port_ram_be
  import sc_dpram_pkg::*;
#(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 8,
  parameter int    BYTE_WIDTH     = 8,
  parameter int    RD_LATENCY     = 1,
  parameter int    RDW_MODE       = 0,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = "",
  localparam int   BE_WIDTH       = calc_be_width(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [BE_WIDTH-1:0]   wr_be_i,
  input  logic                  rd_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  ready_o
`ifdef SC_DPRAM_PARITY_EN
  ,
  output logic                  rd_parity_err_o
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (RDW_MODE != RDW_WRITE_FIRST && RDW_MODE != RDW_READ_FIRST) begin : g_bad_rdw
    $error("RDW_MODE must be 0 or 1");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
    $error("RD_LATENCY must be 1 or 2");
  end

  logic                  w_mem_wr;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;
  logic [BE_WIDTH-1:0]   w_mem_be;
  logic                  w_rd_en;
  logic                  w_hit;

  sc_dpram_clear_seq #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .BE_WIDTH      (BE_WIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (wr_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .wr_be_i   (wr_be_i),
    .rd_i      (rd_i),
    .mem_wr_o  (w_mem_wr),
    .mem_addr_o(w_mem_addr),
    .mem_data_o(w_mem_data),
    .mem_be_o  (w_mem_be),
    .rd_en_o   (w_rd_en),
    .ready_o   (ready_o)
  );

  // NOTE: the array has no reset; the clear sweep zeroes it so it still maps onto block RAM.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  for (genvar k = 0; k < BE_WIDTH; k++) begin : g_lane_wr
    always_ff @(posedge clk_i) begin
      if (w_mem_wr && w_mem_be[k])
        r_mem[w_mem_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_data[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Same-address collision is captured at the read edge and merged one stage later.
  assign w_hit = (RDW_MODE == RDW_WRITE_FIRST) && w_rd_en && w_mem_wr && (w_mem_addr == rd_addr_i);

  logic [DATA_WIDTH-1:0] r_rd_raw;
  logic [DATA_WIDTH-1:0] r_byp_data;
  logic [BE_WIDTH-1:0]   r_byp_be;
  logic                  r_byp_hit;
  logic                  r_valid1;
  logic [DATA_WIDTH-1:0] w_byp_mask;
  logic [DATA_WIDTH-1:0] w_data1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_raw   <= '0;
      r_byp_data <= '0;
      r_byp_be   <= '0;
      r_byp_hit  <= 1'b0;
      r_valid1   <= 1'b0;
    end else begin
      r_valid1 <= w_rd_en;
      if (w_rd_en) begin
        r_rd_raw   <= r_mem[rd_addr_i];
        r_byp_data <= w_mem_data;
        r_byp_be   <= w_mem_be;
        r_byp_hit  <= w_hit;
      end
    end
  end

  for (genvar k = 0; k < BE_WIDTH; k++) begin : g_mask
    assign w_byp_mask[k*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{r_byp_be[k]}};
  end

  assign w_data1 = r_byp_hit ? ((r_byp_data & w_byp_mask) | (r_rd_raw & ~w_byp_mask)) : r_rd_raw;

`ifdef SC_DPRAM_PARITY_EN
  function automatic logic [BE_WIDTH-1:0] lane_par(input logic [DATA_WIDTH-1:0] d);
    logic [MAX_DATA_WIDTH-1:0] ext;
    logic [MAX_BE_WIDTH-1:0]   p;
    ext                   = '0;
    ext[DATA_WIDTH-1:0]   = d;
    p                     = calc_lane_parity(ext, BE_WIDTH, BYTE_WIDTH);
    return p[BE_WIDTH-1:0];
  endfunction

  logic [BE_WIDTH-1:0] r_par [DEPTH];
  logic [BE_WIDTH-1:0] w_mem_par;
  logic [BE_WIDTH-1:0] r_rd_par_raw;
  logic [BE_WIDTH-1:0] r_byp_par;
  logic [BE_WIDTH-1:0] w_par1;
  logic                w_err1;

  assign w_mem_par = lane_par(w_mem_data);

  for (genvar k = 0; k < BE_WIDTH; k++) begin : g_lane_par
    always_ff @(posedge clk_i) begin
      if (w_mem_wr && w_mem_be[k]) r_par[w_mem_addr][k] <= w_mem_par[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_par_raw <= '0;
      r_byp_par    <= '0;
    end else if (w_rd_en) begin
      r_rd_par_raw <= r_par[rd_addr_i];
      r_byp_par    <= w_mem_par;
    end
  end

  assign w_par1 = r_byp_hit ? ((r_byp_par & r_byp_be) | (r_rd_par_raw & ~r_byp_be)) : r_rd_par_raw;
  assign w_err1 = r_valid1 & (|(lane_par(w_data1) ^ w_par1));
`endif

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_rd_data2;
    logic                  r_valid2;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_rd_data2 <= '0;
        r_valid2   <= 1'b0;
      end else begin
        r_valid2 <= r_valid1;
        if (r_valid1) r_rd_data2 <= w_data1;
      end
    end

    assign rd_data_o  = r_rd_data2;
    assign rd_valid_o = r_valid2;

`ifdef SC_DPRAM_PARITY_EN
    logic r_err2;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_err2 <= 1'b0;
      else       r_err2 <= w_err1;
    end
    assign rd_parity_err_o = r_err2;
`endif
  end else begin : g_lat1
    assign rd_data_o  = w_data1;
    assign rd_valid_o = r_valid1;
`ifdef SC_DPRAM_PARITY_EN
    assign rd_parity_err_o = w_err1;
`endif
  end

endmodule
